// File: rtl/uart_frame_rx_pkg.sv
// Shared types and helpers for the UART frame parser.
package uart_frame_pkg;

  // Parser states; HDR means HDR0 seen, waiting for HDR1.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_t;

  localparam logic [7:0] UART_HDR0 = 8'h99;
  localparam logic [7:0] UART_HDR1 = 8'h50;

  // 8-bit wrap-around checksum step; the carry is dropped on purpose.
  function automatic logic [7:0] csum8(input logic [7:0] acc, input logic [7:0] data_byte);
    return acc + data_byte;
  endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte input and frame output bundle of the UART frame parser.
//
// Handshake: rx_valid is a one-cycle strobe and there is no ready signal.
// Every cycle with rx_valid high delivers exactly one byte on rx_data and the
// parser always consumes it, so a source may strobe on consecutive cycles.
// frame_valid, csum_err and timeout_err are one-cycle pulses; frame_data is
// held between frames.
interface uart_frame_rx_if #(
  parameter int PAYLOAD_BYTES = 8
);
  import uart_frame_pkg::*;

  logic                       rx_valid;
  logic [7:0]                 rx_data;
  logic [PAYLOAD_BYTES*8-1:0] frame_data;
  logic                       frame_valid;
  logic                       csum_err;
  logic                       timeout_err;
  logic                       busy;
  state_t                     dbg_state;

  // Byte source / frame consumer side.
  modport master (
    output rx_valid, rx_data,
    input  frame_data, frame_valid, csum_err, timeout_err, busy, dbg_state
  );

  // Parser side.
  modport slave (
    input  rx_valid, rx_data,
    output frame_data, frame_valid, csum_err, timeout_err, busy, dbg_state
  );

endinterface

// File: rtl/uart_frame_rx_timer.sv
// Reloadable inter-byte timer. Counts idle cycles while run is high; a kick
// (new byte) restarts it. expire is raised once TIMEOUT_CYC idle cycles have
// passed, and is masked whenever a byte arrives in the same cycle.
module uart_frame_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] t_q, t_d;

  // Next count: cleared when stopped or kicked, saturates at the limit.
  always_comb begin
    t_d = t_q;
    if (!run || kick) begin
      t_d = '0;
    end else if (t_q != TW'(TIMEOUT_CYC)) begin
      t_d = t_q + TW'(1);
    end
  end

  assign expire = run && !kick && (t_q == TW'(TIMEOUT_CYC));

  // Count register.
  always_ff @(posedge clk_50m) begin
    if (rst) t_q <= '0;
    else     t_q <= t_d;
  end

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame parser: hunts for a two-byte header, gathers PAYLOAD_BYTES
// payload bytes into a shadow buffer, optionally checks a mod-256 checksum,
// and publishes the payload atomically with a one-cycle frame_valid pulse.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HDR0          = UART_HDR0,
  parameter logic [7:0] HDR1          = UART_HDR1,
  parameter int         PAYLOAD_BYTES = 8,
  parameter int         LSB_FIRST     = 1,
  parameter int         CHECKSUM_EN   = 1,
  parameter int         TIMEOUT_CYC   = 50000
) (
  input  logic          clk_50m,
  input  logic          rst,
  uart_frame_rx_if.slave bus
);

  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  localparam int DW = PAYLOAD_BYTES * 8;
  localparam logic [CW-1:0] LAST_SLOT = CW'(PAYLOAD_BYTES - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      acc_q, acc_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic [DW-1:0]   frame_data_q, frame_data_d;
  logic            frame_valid_q, frame_valid_d;
  logic            csum_err_q, csum_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic [CW-1:0]   slot;
  logic            expire;

  if (TIMEOUT_CYC > 0) begin : g_timer
    logic timer_run;
    assign timer_run = (state_q != IDLE);
    uart_frame_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
      .clk_50m (clk_50m),
      .rst     (rst),
      .run     (timer_run),
      .kick    (bus.rx_valid),
      .expire  (expire)
    );
  end else begin : g_no_timer
    assign expire = 1'b0;
  end

  // Next-state, buffer and pulse logic. A byte always takes priority over a
  // coincident timer expiry.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    shadow_d      = shadow_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    csum_err_d    = 1'b0;
    timeout_err_d = 1'b0;
    slot          = (LSB_FIRST != 0) ? cnt_q : (LAST_SLOT - cnt_q);

    if (bus.rx_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_data == HDR0) state_d = HDR;
        end
        HDR: begin
          if (bus.rx_data == HDR1) begin
            state_d = PAYLOAD;
            cnt_d   = '0;
            acc_d   = '0;
          end else if (bus.rx_data != HDR0) begin
            // A repeated HDR0 keeps us in HDR so the header can resync.
            state_d = IDLE;
          end
        end
        PAYLOAD: begin
          shadow_d[{slot, 3'b000} +: 8] = bus.rx_data;
          acc_d = csum8(acc_q, bus.rx_data);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_SLOT) begin
            if (CHECKSUM_EN != 0) begin
              state_d = CSUM;
            end else begin
              frame_data_d  = shadow_d;
              frame_valid_d = 1'b1;
              state_d       = IDLE;
            end
          end
        end
        CSUM: begin
          if (bus.rx_data == acc_q) begin
            frame_data_d  = shadow_q;
            frame_valid_d = 1'b1;
          end else begin
            csum_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (expire) begin
      timeout_err_d = 1'b1;
      state_d       = IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      csum_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      csum_err_q    <= csum_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.csum_err    = csum_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: two instances share one byte stream. dut_a uses
// the default parameters; dut_b is MSB-first with a 20-cycle timeout.
module tb_uart_frame_rx;
  import uart_frame_pkg::*;

  localparam int         N    = 8;
  localparam int         TO_A = 50000;
  localparam int         TO_B = 20;
  localparam logic [7:0] H0   = 8'h99;
  localparam logic [7:0] H1   = 8'h50;

  typedef logic [7:0] payload_t [N];

  logic clk = 1'b0;
  logic rst;

  uart_frame_rx_if #(.PAYLOAD_BYTES(N)) if_a ();
  uart_frame_rx_if #(.PAYLOAD_BYTES(N)) if_b ();

  uart_frame_rx #(
    .HDR0(H0), .HDR1(H1), .PAYLOAD_BYTES(N),
    .LSB_FIRST(1), .CHECKSUM_EN(1), .TIMEOUT_CYC(TO_A)
  ) dut_a (
    .clk_50m (clk),
    .rst     (rst),
    .bus     (if_a)
  );

  uart_frame_rx #(
    .HDR0(H0), .HDR1(H1), .PAYLOAD_BYTES(N),
    .LSB_FIRST(0), .CHECKSUM_EN(1), .TIMEOUT_CYC(TO_B)
  ) dut_b (
    .clk_50m (clk),
    .rst     (rst),
    .bus     (if_b)
  );

  // Clock / reset: 50 MHz clock; reset is sequenced by the main block.
  always #10 clk = ~clk;

  // Scoreboard state.
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] last_a   = '0;
  logic [63:0] last_b   = '0;

  // Pulse monitor, sampled 1 ns after each rising edge.
  int fv_a = 0, ce_a = 0, te_a = 0, fv_b = 0, ce_b = 0, te_b = 0, ovl = 0;
  always @(posedge clk) begin
    #1;
    if (if_a.frame_valid) fv_a++;
    if (if_a.csum_err)    ce_a++;
    if (if_a.timeout_err) te_a++;
    if (if_b.frame_valid) fv_b++;
    if (if_b.csum_err)    ce_b++;
    if (if_b.timeout_err) te_b++;
    if ((if_a.frame_valid && if_a.csum_err) || (if_a.frame_valid && if_a.timeout_err) ||
        (if_a.csum_err && if_a.timeout_err) ||
        (if_b.frame_valid && if_b.csum_err) || (if_b.frame_valid && if_b.timeout_err) ||
        (if_b.csum_err && if_b.timeout_err))
      ovl++;
  end

  // Reference model: slot k of the payload lands at byte k (LSB first) or at
  // byte N-1-k (MSB first).
  function automatic logic [63:0] pack(input payload_t p, input bit lsb_first);
    logic [63:0] v = '0;
    for (int k = 0; k < N; k++) begin
      if (lsb_first) v[8*k +: 8] = p[k];
      else           v[8*(N-1-k) +: 8] = p[k];
    end
    return v;
  endfunction

  function automatic logic [7:0] sum8(input payload_t p);
    int s = 0;
    for (int k = 0; k < N; k++) s = (s + int'(p[k])) % 256;
    return 8'(s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Driver tasks: called at a falling edge, return at a falling edge.
  task automatic drive_byte(input logic [7:0] b);
    if_a.rx_valid = 1'b1; if_a.rx_data = b;
    if_b.rx_valid = 1'b1; if_b.rx_data = b;
    @(negedge clk);
    if_a.rx_valid = 1'b0;
    if_b.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input payload_t p, input logic [7:0] cs, input int gap, input bit ok);
    int f0a = fv_a, c0a = ce_a, t0a = te_a, f0b = fv_b, c0b = ce_b, t0b = te_b;
    logic [63:0] ea = pack(p, 1'b1);
    logic [63:0] eb = pack(p, 1'b0);
    drive_byte(H0); idle(gap);
    drive_byte(H1); idle(gap);
    for (int k = 0; k < N; k++) begin
      drive_byte(p[k]); idle(gap);
    end
    drive_byte(cs);
    if (ok) begin
      exp_q.push_back(ea);
      chk("frame_valid_a", 64'(if_a.frame_valid), 64'(1));
      chk("frame_data_a", if_a.frame_data, exp_q.pop_front());
      chk("frame_data_b", if_b.frame_data, eb);
      last_a = ea;
      last_b = eb;
    end else begin
      chk("csum_err_a", 64'(if_a.csum_err), 64'(1));
      chk("no_frame_a", 64'(if_a.frame_valid), 64'(0));
      chk("held_data_a", if_a.frame_data, last_a);
      chk("held_data_b", if_b.frame_data, last_b);
    end
    idle(2);
    chk("frames_a", 64'(fv_a - f0a), 64'(ok));
    chk("csum_errs_a", 64'(ce_a - c0a), 64'(!ok));
    chk("timeouts_a", 64'(te_a - t0a), 64'(0));
    chk("frames_b", 64'(fv_b - f0b), 64'(ok));
    chk("csum_errs_b", 64'(ce_b - c0b), 64'(!ok));
    chk("timeouts_b", 64'(te_b - t0b), 64'(0));
    chk("busy_a_after", 64'(if_a.busy), 64'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_a"}, if_a.frame_data, 64'(0));
    chk({tag, "_data_b"}, if_b.frame_data, 64'(0));
    chk({tag, "_fv_a"}, 64'(if_a.frame_valid), 64'(0));
    chk({tag, "_ce_a"}, 64'(if_a.csum_err), 64'(0));
    chk({tag, "_te_a"}, 64'(if_a.timeout_err), 64'(0));
    chk({tag, "_busy_a"}, 64'(if_a.busy), 64'(0));
    chk({tag, "_busy_b"}, 64'(if_b.busy), 64'(0));
    chk({tag, "_state_a"}, 64'(if_a.dbg_state), 64'(IDLE));
  endtask

  // Directed sequence with randomized payloads.
  initial begin
    payload_t p;
    payload_t base;
    int f0a, c0a, t0a, t0b, f0b;

    for (int k = 0; k < N; k++) base[k] = 8'(k + 1);
    if_a.rx_valid = 1'b0; if_a.rx_data = '0;
    if_b.rx_valid = 1'b0; if_b.rx_data = '0;
    rst = 1'b1;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Known vector: 99 50 01..08 24, both byte orders.
    chk("base_csum", 64'(sum8(base)), 64'(8'h24));
    send_frame(base, 8'h24, 0, 1'b1);
    chk("vec_lsb", last_a, 64'h0807060504030201);
    chk("vec_msb", last_b, 64'h0102030405060708);

    // Wrong checksum: dropped, data held.
    send_frame(base, 8'h25, 0, 1'b0);

    // Random payloads with random small inter-byte gaps.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) p[k] = 8'($urandom_range(0, 255));
      send_frame(p, sum8(p), int'($urandom_range(0, 3)), 1'b1);
    end

    // Random bad checksum.
    for (int k = 0; k < N; k++) p[k] = 8'($urandom_range(0, 255));
    send_frame(p, sum8(p) ^ 8'($urandom_range(1, 255)), 0, 1'b0);

    // Header resync: 99 99 99 50 <frame>.
    drive_byte(H0); drive_byte(H0);
    for (int k = 0; k < N; k++) p[k] = 8'($urandom_range(0, 255));
    send_frame(p, sum8(p), 0, 1'b1);

    // Broken header 99 51 is discarded, following frame accepted.
    drive_byte(H0); drive_byte(8'h51);
    for (int k = 0; k < N; k++) p[k] = 8'($urandom_range(0, 255));
    send_frame(p, sum8(p), 0, 1'b1);

    // Long idle mid-frame: both instances time out once.
    f0a = fv_a; c0a = ce_a; t0a = te_a; t0b = te_b; f0b = fv_b;
    drive_byte(H0); drive_byte(H1); drive_byte(8'h01); drive_byte(8'h02);
    chk("busy_a_partial", 64'(if_a.busy), 64'(1));
    idle(TO_A + 10);
    chk("timeout_a_once", 64'(te_a - t0a), 64'(1));
    chk("timeout_b_once", 64'(te_b - t0b), 64'(1));
    chk("timeout_no_frame_a", 64'(fv_a - f0a), 64'(0));
    chk("timeout_no_frame_b", 64'(fv_b - f0b), 64'(0));
    chk("timeout_no_csum_a", 64'(ce_a - c0a), 64'(0));
    chk("timeout_busy_a", 64'(if_a.busy), 64'(0));
    chk("timeout_busy_b", 64'(if_b.busy), 64'(0));
    for (int k = 0; k < N; k++) p[k] = 8'($urandom_range(0, 255));
    send_frame(p, sum8(p), 0, 1'b1);

    // Gap of exactly TO_B idle cycles: byte meets expiry, byte wins.
    for (int k = 0; k < N; k++) p[k] = 8'($urandom_range(0, 255));
    send_frame(p, sum8(p), TO_B, 1'b1);

    // Gap of TO_B+1 times out dut_b only; then reset dut_a after its 4th
    // payload byte.
    f0a = fv_a; c0a = ce_a; t0a = te_a; t0b = te_b;
    drive_byte(H0); drive_byte(H1); drive_byte(8'h01); drive_byte(8'h02);
    idle(TO_B + 1);
    drive_byte(8'h03); drive_byte(8'h04);
    chk("pre_reset_busy_a", 64'(if_a.busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midreset");
    idle(3);
    chk("midreset_timeout_b", 64'(te_b - t0b), 64'(1));
    chk("midreset_timeout_a", 64'(te_a - t0a), 64'(0));
    chk("midreset_csum_a", 64'(ce_a - c0a), 64'(0));
    chk("midreset_frames_a", 64'(fv_a - f0a), 64'(0));
    last_a = '0;
    last_b = '0;

    // Default frame, back-to-back bytes, after reset.
    send_frame(base, sum8(base), 0, 1'b1);

    chk("pulse_overlap", 64'(ovl), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
